// File: rtl/fnn_pkg.sv
// Shared types and default constants for the fully connected network datapath.
// Contents:
//   ser_state_t     - layer_serializer FSM states
//   FNN_DATA_WIDTH  - default neuron word width
//   FNN_SER_GAP     - default idle cycles between serial bursts
package fnn_pkg;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_GAP
  } ser_state_t;

  localparam int FNN_DATA_WIDTH = 16;
  localparam int FNN_SER_GAP    = 8;

endpackage

// File: rtl/ser_bank.sv
// One capture bank of the layer serializer: holds a full layer result and
// presents one selected word of it.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears the full flag)
//   load      - capture in_data into the bank and mark it full
//   clear     - mark the bank empty (last word has been issued)
//   in_data   - numNeurons packed words, word k at [k*dataWidth +: dataWidth]
//   sel       - index of the word presented on word
//   word      - selected stored word
//   full      - bank holds a result not yet completely sent
module ser_bank #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  localparam int IDX_W     = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            clear,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  input  logic [IDX_W-1:0]                sel,
  output logic [dataWidth-1:0]            word,
  output logic                            full
);

  logic [dataWidth-1:0] mem [numNeurons];

  // A load and a clear can coincide when the bank is released on its last
  // beat and refilled in the same cycle; the new result must win.
  always_ff @(posedge clk) begin
    if (rst)
      full <= 1'b0;
    else if (load)
      full <= 1'b1;
    else if (clear)
      full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < numNeurons; k++)
        mem[k] <= in_data[k*dataWidth +: dataWidth];
    end
  end

  assign word = mem[sel];

endmodule

// File: rtl/layer_serializer.sv
// Transmit end of the inter-layer neuron stream. Captures a whole layer result
// in one cycle into one of two banks and replays it as a gapless burst of
// numNeurons words, followed by at least interBurstGap idle cycles.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   in_data    - parallel neuron outputs, word k at [k*dataWidth +: dataWidth]
//   in_valid   - single-cycle capture strobe
//   out_data   - serial word to the next layer (registered)
//   out_valid  - out_data valid this cycle (registered)
//   busy       - a bank is occupied or a burst/gap is in progress
//   overflow   - sticky; a capture was dropped because both banks were full
module layer_serializer
  import fnn_pkg::*;
#(
  parameter int numNeurons    = 30,
  parameter int dataWidth     = FNN_DATA_WIDTH,
  parameter int interBurstGap = FNN_SER_GAP
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  input  logic                            in_valid,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            overflow
);

  localparam int IDX_W = $clog2(numNeurons);
  localparam int GAP_W = $clog2(interBurstGap + 1);

  ser_state_t           state, state_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [GAP_W-1:0]     gap_cnt, gap_next;
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           full, load, clear;
  logic [dataWidth-1:0] bank_word [2];
  logic [IDX_W-1:0]     read_sel;
  logic                 release_now, bank_free, capture, drop;
  logic [dataWidth-1:0] out_data_next;
  logic                 out_valid_next;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ser_bank #(
      .numNeurons(numNeurons),
      .dataWidth (dataWidth)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .load   (load[b]),
      .clear  (clear[b]),
      .in_data(in_data),
      .sel    (read_sel),
      .word   (bank_word[b]),
      .full   (full[b])
    );
  end

  // The state/idx registers describe what is on the output registers right
  // now, so the bank is read one word ahead (idx+1) to feed the next beat.
  // Full banks always form a run starting at rd_ptr, hence when both are
  // full the write pointer equals the read pointer and a release frees it.
  always_comb begin
    release_now = (state == SER_SEND) && (idx == IDX_W'(numNeurons - 1));
    bank_free   = !full[wr_ptr] || (release_now && (wr_ptr == rd_ptr));
    capture     = in_valid && bank_free;
    drop        = in_valid && !bank_free;
    load        = '0;
    clear       = '0;
    if (capture)
      load[wr_ptr] = 1'b1;
    if (release_now)
      clear[rd_ptr] = 1'b1;
    read_sel = '0;
    if ((state == SER_SEND) && !release_now)
      read_sel = idx + IDX_W'(1);
  end

  // Next-state and next-output logic. From IDLE a result arriving this very
  // cycle into the empty read bank is forwarded straight from in_data so the
  // first beat appears the cycle after the strobe. The GAP state covers all
  // but one idle cycle; the final one is spent in IDLE choosing the next bank.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    gap_next       = gap_cnt;
    out_valid_next = 1'b0;
    out_data_next  = '0;
    unique case (state)
      SER_IDLE: begin
        if (full[rd_ptr]) begin
          state_next     = SER_SEND;
          idx_next       = '0;
          out_valid_next = 1'b1;
          out_data_next  = bank_word[rd_ptr];
        end else if (capture) begin
          state_next     = SER_SEND;
          idx_next       = '0;
          out_valid_next = 1'b1;
          out_data_next  = in_data[dataWidth-1:0];
        end
      end
      SER_SEND: begin
        if (release_now) begin
          state_next = SER_GAP;
          idx_next   = '0;
          gap_next   = GAP_W'(interBurstGap - 1);
        end else begin
          idx_next       = idx + IDX_W'(1);
          out_valid_next = 1'b1;
          out_data_next  = bank_word[rd_ptr];
        end
      end
      SER_GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          state_next = SER_IDLE;
          gap_next   = '0;
        end else begin
          gap_next = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_next = SER_IDLE;
      end
    endcase
  end

  // State, pointers and registered outputs. busy reflects the occupancy seen
  // in the previous cycle, including a capture being accepted then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SER_IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      gap_cnt   <= gap_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      busy      <= (state != SER_IDLE) || (|full) || capture;
      if (capture)
        wr_ptr <= ~wr_ptr;
      if (release_now)
        rd_ptr <= ~rd_ptr;
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer (numNeurons=4). A burst-level
// reference model schedules every accepted result and predicts out_valid,
// out_data, busy and overflow each cycle; a behavioural downstream neuron
// checks that bursts are consumed as whole vectors.
module tb_layer_serializer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int G  = 8;
  localparam int IW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;
  int beats    = 0;

  always #5 clk = ~clk;

  layer_serializer #(
    .numNeurons   (N),
    .dataWidth    (DW),
    .interBurstGap(G)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy),
    .overflow (overflow)
  );

  // Reference model: each accepted result occupies a bank from its capture
  // until its last beat; bursts start the cycle after capture or G+1 cycles
  // after the previous burst's last beat, whichever is later.
  typedef struct {
    int            cap;
    int            start;
    int            last;
    logic [IW-1:0] d;
  } burst_t;

  burst_t bq[$];
  int     lastEnd = -1000;
  int     ovfFrom = -1;

  // Downstream neuron: accumulates while valid, fires on the falling edge.
  int wgt [N];
  int bias   = 0;
  int acc    = 0;
  int nk     = 0;
  logic prevValid = 1'b0;
  int nOut[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1)
      beats <= beats + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      acc       <= 0;
      nk        <= 0;
      prevValid <= 1'b0;
    end else begin
      if (out_valid === 1'b1) begin
        acc <= acc + int'($signed(out_data)) * wgt[nk % N];
        nk  <= nk + 1;
      end else if (prevValid) begin
        nOut.push_back(acc + bias);
        acc <= 0;
        nk  <= 0;
      end
      prevValid <= (out_valid === 1'b1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    bq.delete();
    lastEnd = -1000;
    ovfFrom = -1;
  endtask

  task automatic modelInput(input int c, input logic v, input logic [IW-1:0] d);
    int     occ;
    burst_t b;
    while (bq.size() > 0 && bq[0].last + G + 1 < c)
      void'(bq.pop_front());
    if (v) begin
      occ = 0;
      foreach (bq[i])
        if (bq[i].last > c) occ++;
      if (occ < 2) begin
        b.cap   = c;
        b.start = (c + 1 > lastEnd + G + 1) ? c + 1 : lastEnd + G + 1;
        b.last  = b.start + N - 1;
        b.d     = d;
        bq.push_back(b);
        lastEnd = b.last;
      end else if (ovfFrom < 0) begin
        ovfFrom = c + 1;
      end
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance.
  task automatic applyStimulus(input logic r, input logic v, input logic [IW-1:0] d);
    logic          expV, expB, expO;
    logic [DW-1:0] expD;
    rst      = r;
    in_valid = v;
    in_data  = d;
    if (!r)
      modelInput(cyc, v, d);
    @(negedge clk);
    expV = 1'b0;
    expB = 1'b0;
    expD = '0;
    foreach (bq[i]) begin
      if (bq[i].start <= cyc && cyc <= bq[i].last) begin
        expV = 1'b1;
        expD = bq[i].d[(cyc - bq[i].start)*DW +: DW];
      end
      if (bq[i].cap < cyc && cyc <= bq[i].last + G)
        expB = 1'b1;
    end
    expO = (ovfFrom >= 0) && (cyc >= ovfFrom);
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expV});
    checkOutput("busy", {31'd0, busy}, {31'd0, expB});
    checkOutput("overflow", {31'd0, overflow}, {31'd0, expO});
    if (expV)
      checkOutput("out_data", {16'd0, out_data}, {16'd0, expD});
    if (r)
      modelReset();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idleUntil(input int target);
    while (cyc < target)
      applyStimulus(1'b0, 1'b0, {$urandom(), $urandom()});
  endtask

  task automatic pulse(input int at, input logic [IW-1:0] d);
    idleUntil(at);
    applyStimulus(1'b0, 1'b1, d);
  endtask

  function automatic int golden(input logic [IW-1:0] d);
    int s;
    s = bias;
    for (int k = 0; k < N; k++)
      s += int'($signed(d[k*DW +: DW])) * wgt[k];
    return s;
  endfunction

  initial begin
    logic [IW-1:0] da, db;
    int            b0;
    int            g0, g1;

    // Power-up reset, then the reset state itself.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    modelReset();
    rst = 1'b0;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_out_data", {16'd0, out_data}, 32'd0);

    // Single result, including a most-negative word.
    base = cyc;
    b0   = beats;
    pulse(base + 10, {16'h8000, 16'h0003, 16'h0002, 16'h0001});
    idleUntil(base + 40);
    checkOutput("single_beats", beats - b0, N);

    // Two results back-to-back.
    base = cyc;
    b0   = beats;
    pulse(base + 10, {$urandom(), $urandom()});
    pulse(base + 12, {$urandom(), $urandom()});
    idleUntil(base + 50);
    checkOutput("b2b_beats", beats - b0, 2 * N);
    checkOutput("b2b_overflow", {31'd0, overflow}, 32'd0);

    // Release/capture coincidence on the last beat of burst 1.
    base = cyc;
    b0   = beats;
    pulse(base + 10, {$urandom(), $urandom()});
    pulse(base + 11, {$urandom(), $urandom()});
    pulse(base + 14, {$urandom(), $urandom()});
    idleUntil(base + 70);
    checkOutput("coincide_beats", beats - b0, 3 * N);
    checkOutput("coincide_overflow", {31'd0, overflow}, 32'd0);

    // Overflow: third pulse dropped, overflow sticky until reset.
    base = cyc;
    b0   = beats;
    pulse(base + 10, {$urandom(), $urandom()});
    pulse(base + 11, {$urandom(), $urandom()});
    pulse(base + 12, {$urandom(), $urandom()});
    idleUntil(base + 50);
    checkOutput("ovf_beats", beats - b0, 2 * N);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Reset on the second beat, then a clean burst.
    base = cyc;
    b0   = beats;
    pulse(base + 10, {$urandom(), $urandom()});
    idleUntil(base + 12);
    applyStimulus(1'b1, 1'b0, {$urandom(), $urandom()});
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    pulse(base + 16, {16'h7FFF, 16'hFFFF, 16'h1234, 16'hABCD});
    idleUntil(base + 40);
    checkOutput("midrst_beats", beats - b0, 2 + N);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 249) == 0), ($urandom_range(0, 9) == 0),
                    {$urandom(), $urandom()});
    applyStimulus(1'b1, 1'b0, '0);
    idleUntil(cyc + 5);

    // Downstream neuron consuming two consecutive results.
    for (int k = 0; k < N; k++)
      wgt[k] = $urandom_range(0, 200) - 100;
    bias = $urandom_range(0, 2000) - 1000;
    da   = {$urandom(), $urandom()};
    db   = {$urandom(), $urandom()};
    g0   = golden(da);
    g1   = golden(db);
    nOut.delete();
    base = cyc;
    pulse(base + 10, da);
    pulse(base + 12, db);
    idleUntil(base + 50);
    checkOutput("neuron_count", nOut.size(), 2);
    checkOutput("neuron_sum0", (nOut.size() > 0) ? nOut[0] : 32'hDEADBEEF, g0);
    checkOutput("neuron_sum1", (nOut.size() > 1) ? nOut[1] : 32'hDEADBEEF, g1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Transmit end of the inter-layer neuron data stream. It captures the parallel outputs of one fully connected layer (numNeurons words, all presented in the same cycle) and replays them as a gapless serial burst on out_data/out_valid, one word per cycle, in the form the next layer's neurons consume on myinput/myinputValid. It sits between the neuron array of layer N and the broadcast input of layer N+1. Two capture banks let a new layer result arrive while the previous burst is still being sent.

## Interface
- numNeurons, 30, words per layer result; equals numWeight of the downstream layer
- dataWidth, 16, bits per word
- interBurstGap, 8, minimum idle cycles between bursts; lets the downstream neurons finish bias-add, output and accumulator clear
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  numNeurons*dataWidth  neuron outputs; word k = in_data[k*dataWidth +: dataWidth]
- in_valid  in  1  capture strobe: outvalid of the upstream neuron array, single-cycle pulse
- out_data  out  dataWidth  serial word to the next layer
- out_valid  out  1  out_data is valid this cycle
- busy  out  1  high while any bank is full or the FSM is not IDLE
- overflow  out  1  sticky; set when a capture is dropped

## Operation
- Banks: two numNeurons×dataWidth registers, each with a full flag. The write pointer selects the next bank to fill; the read pointer selects the bank being sent. Both pointers toggle.
- Capture: when in_valid=1 and a bank is free, load all words into bank[wr_ptr], set its full flag and toggle wr_ptr.
- Drop: when in_valid=1 and both banks are full with no release in the same cycle, drop the capture, set overflow and leave the banks unchanged.
- Release: the send bank's flag clears in the cycle its last word is issued. A capture in that same cycle is accepted.
- FSM states:
  - IDLE: if bank[rd_ptr] is full, go to SEND with idx=0.
  - SEND: drive word idx of bank[rd_ptr] with out_valid=1. Increment idx. At idx=numNeurons-1, release the bank, toggle rd_ptr and go to GAP with gap_cnt=interBurstGap-1.
  - GAP: hold out_valid=0 and decrement gap_cnt. At 0, go to IDLE.
- Word order: word 0 is sent first. Data is passed through unchanged, with no saturation or sign handling; it is raw signed Q-format.
- Burst shape: every burst is exactly numNeurons consecutive valid beats. The downstream accumulator detects end-of-vector from the falling edge of valid, so a gap inside a burst is illegal.
- Reset values: out_data=0, out_valid=0, busy=0, overflow=0, FSM=IDLE, idx=0, gap_cnt=0, both pointers 0, both flags clear.
- Reset mid-burst: the burst is aborted, out_valid=0 from the next cycle and banks are emptied. overflow clears only on rst.

## Timing
- Latency: in_valid high in cycle c with FSM IDLE and banks empty gives the first out_valid in cycle c+1 and the last in c+numNeurons. out_data and out_valid are registered.
- Back-to-back results: the next burst starts no earlier than interBurstGap+1 cycles after the last beat of the previous burst, counting the IDLE→SEND cycle.
- busy rises in c+1 after an accepted capture. It falls the first cycle the FSM is IDLE with both banks empty.
- overflow rises the cycle after the dropped in_valid.
- Widths: idx is $clog2(numNeurons) bits and gap_cnt is $clog2(interBurstGap+1) bits. Both wrap-free, because the FSM bounds them.

## Structure
- Shared package fnn_pkg: typedef enum logic [1:0] {SER_IDLE, SER_SEND, SER_GAP} ser_state_t, plus default constants FNN_DATA_WIDTH=16 and FNN_SER_GAP=8.
- One sub-module, ser_bank: a single capture bank (load enable, parallel in, word select out, full flag with set/clear), instantiated twice. The top level holds the pointers, FSM, counters and output registers.
- Expected size is about 200 lines total.

## Test plan
- Single result: numNeurons=4, in_valid at c=10 with words 0x0001,0x0002,0x0003,0x8000 → out_valid in cycles 11–14 carrying 0x0001,0x0002,0x0003,0x8000, then out_valid=0. busy falls at cycle 15+interBurstGap.
- Two results back-to-back: in_valid at c=10 (A) and c=12 (B) → A sent in 11–14, B starts at cycle 14+interBurstGap+1. overflow=0.
- Overflow: three in_valid pulses at c=10, 11, 12 → third is dropped and overflow=1 from cycle 13. Only two bursts are sent.
- Release/capture coincidence: both banks full, third in_valid in the last-beat cycle of burst 1 → accepted and sent as burst 3. overflow stays 0.
- Reset mid-burst: rst at the second beat → out_valid=0 and busy=0 the next cycle. A new in_valid after reset gives a clean full burst from word 0.
- Downstream integration: drive one layer-1 neuron (numWeight=numNeurons) from out_data/out_valid for two consecutive results → exactly one outvalid per burst, with a sum matching the golden dot product plus bias.
